ps2_key_sequencer: RTL and testbench

- Controller that sits between the PS/2 byte receiver and the game logic.
- Consumes raw scan-code bytes and sequences the Set-2 prefix protocol (E0 = extended, F0 = break) into complete key events.
- Queues completed events in a small FIFO behind a valid/ready handshake.
- Maintains a live pressed-state vector for the four arrow keys, which drive cursor movement.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_evt_fifo.sv | 59 +++++
 rtl/ps2_key_sequencer.sv | 150 +++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event record for the PS/2 key sequencer.
package ps2_pkg;

    // Set-2 prefix and keyboard control bytes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Key codes the game logic cares about (arrows only count when E0-prefixed)
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Bytes that are keyboard status/control chatter, never key codes
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_PAUSE) ||
               (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small event FIFO. Head is presented combinationally; when empty the
// output holds the most recently popped entry (zero after reset).
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en_i,
    input  ps2_evt_t wr_data_i,
    input  logic     rd_en_i,
    output ps2_evt_t rd_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = $clog2(DEPTH);

    ps2_evt_t          mem_q [DEPTH];
    ps2_evt_t          last_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q;
    logic              wr, rd;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A full FIFO still accepts a write when the head is leaving this cycle
    assign wr      = wr_en_i && (!full_o || rd_en_i);
    assign rd      = rd_en_i && !empty_o;
    assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    // Storage array; contents are only observed while occupied, so no reset
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointers, occupancy and the hold-last-value register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns raw Set-2 scan bytes into complete key events, queues them behind a
// valid/ready handshake and tracks which extended arrow keys are held.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [3:0] held_arrows,
    output logic       overflow,
    output logic       seq_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              restart;
    logic              push;
    ps2_evt_t          evt_d, head;
    logic              tmo_d, tmo_q;
    logic [3:0]        held_q;
    logic              ovf_q;
    logic              full, empty, pop;

    assign evt_valid   = !empty;
    assign pop         = evt_valid && evt_ready;
    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_break   = head.brk;
    assign held_arrows = held_q;
    assign overflow    = ovf_q;
    assign seq_timeout = tmo_q;

    // FSM state register and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Prefix sequencing: next state, event completion and timeout
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        evt_d   = '0;
        restart = 1'b0;
        tmo_d   = 1'b0;
        if (byte_valid) begin
            if (frame_err) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_in == PS2_EXT)      state_d = S_EXT;
                        else if (byte_in == PS2_BRK) state_d = S_BRK;
                        else if (!is_ctrl_byte(byte_in)) begin
                            push  = 1'b1;
                            evt_d = '{ext: 1'b0, brk: 1'b0, code: byte_in};
                        end
                    end
                    S_EXT: begin
                        if (byte_in == PS2_BRK)      state_d = S_EXT_BRK;
                        else if (byte_in == PS2_EXT) restart = 1'b1;
                        else begin
                            push    = 1'b1;
                            evt_d   = '{ext: 1'b1, brk: 1'b0, code: byte_in};
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        state_d = S_IDLE;
                        if (byte_in != PS2_EXT && byte_in != PS2_BRK) begin
                            push  = 1'b1;
                            evt_d = '{ext: 1'b0, brk: 1'b1, code: byte_in};
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        if (byte_in != PS2_EXT && byte_in != PS2_BRK) begin
                            push  = 1'b1;
                            evt_d = '{ext: 1'b1, brk: 1'b1, code: byte_in};
                        end
                    end
                endcase
            end
        end else if (state_q != S_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            tmo_d   = 1'b1;
        end
    end

    // Timeout counter: zero on entry to (or restart of) a prefix state
    always_comb begin
        cnt_d = '0;
        if (state_d != S_IDLE && state_d == state_q && !restart)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Arrow state and sticky overflow, updated whether or not the FIFO has room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push && evt_d.ext) begin
                case (evt_d.code)
                    KEY_UP:    held_q[3] <= !evt_d.brk;
                    KEY_DOWN:  held_q[2] <= !evt_d.brk;
                    KEY_LEFT:  held_q[1] <= !evt_d.brk;
                    KEY_RIGHT: held_q[0] <= !evt_d.brk;
                    default:   held_q    <= held_q;
                endcase
            end
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (evt_d),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty)
    );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a queue-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       frame_err = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break;
    logic [3:0] held_arrows;
    logic       overflow, seq_timeout;

    int checks = 0;
    int errors = 0;

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_err(frame_err), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .held_arrows(held_arrows), .overflow(overflow), .seq_timeout(seq_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A sequence is "open" after a prefix; it remembers which prefixes were
    // seen and how many idle cycles have elapsed since the last prefix.
    bit          m_open, m_ext, m_brk, m_ovf, m_tmo;
    int          m_age;
    logic [9:0]  mq[$];
    logic [9:0]  m_last;
    logic [3:0]  m_held;

    task automatic m_reset();
        m_open = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_tmo = 0; m_age = 0;
        mq.delete(); m_last = '0; m_held = '0;
    endtask

    task automatic m_emit(input bit e, input bit b, input logic [7:0] c);
        if (e) begin
            if (c == 8'h75) m_held[3] = !b;
            if (c == 8'h72) m_held[2] = !b;
            if (c == 8'h6B) m_held[1] = !b;
            if (c == 8'h74) m_held[0] = !b;
        end
        if (mq.size() < DEPTH) mq.push_back({e, b, c});
        else m_ovf = 1;
    endtask

    task automatic m_step();
        m_tmo = 0;
        if (mq.size() != 0 && evt_ready) m_last = mq.pop_front();
        if (byte_valid) begin
            if (frame_err) m_open = 0;
            else if (!m_open) begin
                if (byte_in == 8'hE0)      begin m_open = 1; m_ext = 1; m_brk = 0; m_age = 0; end
                else if (byte_in == 8'hF0) begin m_open = 1; m_ext = 0; m_brk = 1; m_age = 0; end
                else if (!(byte_in inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF}))
                    m_emit(0, 0, byte_in);
            end else if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
                // only "E0 then more prefixes" continues; everything else aborts
                if (m_ext && !m_brk) begin
                    if (byte_in == 8'hF0) m_brk = 1;
                    m_age = 0;
                end else m_open = 0;
            end else begin
                m_emit(m_ext, m_brk, byte_in);
                m_open = 0;
            end
        end else if (m_open) begin
            if (m_age == TMO - 1) begin m_open = 0; m_tmo = 1; end
            else m_age++;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // Compare DUT against the model away from the active edge
    initial begin
        logic [9:0] head;
        forever begin
            @(negedge clk);
            head = (mq.size() != 0) ? mq[0] : m_last;
            chk("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
            chk("evt_head", 32'({evt_ext, evt_break, evt_code}), 32'(head));
            chk("held_arrows", 32'(held_arrows), 32'(m_held));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("seq_timeout", 32'(seq_timeout), 32'(m_tmo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fe = 1'b0);
        byte_in = b; byte_valid = 1'b1; frame_err = fe;
        tick();
        byte_valid = 1'b0; frame_err = 1'b0;
    endtask

    task automatic chk_evt(input string nm, input logic v, input logic e, input logic b,
                           input logic [7:0] c);
        chk({nm, "_valid"}, 32'(evt_valid), 32'(v));
        chk({nm, "_evt"}, 32'({evt_ext, evt_break, evt_code}), 32'({e, b, c}));
    endtask

    initial begin
        logic [7:0] drain [4];
        drain[0] = 8'h1C; drain[1] = 8'h32; drain[2] = 8'h21; drain[3] = 8'h23;

        tick(); tick();
        chk("rst_outs", 32'({evt_valid, evt_code, evt_ext, evt_break, held_arrows, overflow, seq_timeout}), 32'h0);
        rst = 1'b0;
        tick();

        // plain make, popped one cycle after it appears, value then held
        send(8'h1C);
        chk_evt("make", 1, 0, 0, 8'h1C);
        tick();
        chk_evt("make_drop", 0, 0, 0, 8'h1C);

        // control bytes in idle are discarded
        send(8'hAA); send(8'hFA);
        chk("ctrl_discard", 32'(evt_valid), 32'h0);

        // extended make / break of UP
        send(8'hE0); send(8'h75);
        chk_evt("ext_make", 1, 1, 0, 8'h75);
        chk("held_up", 32'(held_arrows), 32'h8);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_evt("ext_brk", 1, 1, 1, 8'h75);
        chk("held_clr", 32'(held_arrows), 32'h0);
        tick();

        // break prefix abandoned after TMO idle cycles
        send(8'hF0);
        for (int i = 1; i <= TMO + 1; i++) begin
            tick();
            chk("tmo_pulse", 32'(seq_timeout), 32'(i == TMO));
        end
        chk("tmo_noevt", 32'(evt_valid), 32'h0);
        send(8'h1C);
        chk_evt("after_tmo", 1, 0, 0, 8'h1C);
        tick();

        // E0 E0 restarts timer: byte at TMO-1 idle cycles after 2nd E0 still extends
        send(8'hE0); repeat (5) tick(); send(8'hE0);
        repeat (TMO - 1) tick();
        send(8'h72);
        chk_evt("e0e0_ext", 1, 1, 0, 8'h72);
        chk("held_down", 32'(held_arrows), 32'h4);
        send(8'hE0); send(8'hF0); send(8'h72);
        tick();

        // overflow: fifth event dropped, first four drain in order
        evt_ready = 1'b0;
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_valid", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain", 32'(evt_code), 32'(drain[i]));
            tick();
        end
        chk("drain_empty", 32'(evt_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // full FIFO with simultaneous push and pop keeps all entries
        evt_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        evt_ready = 1'b1;
        send(8'h15);
        repeat (5) tick();

        // frame error discards the byte and resets the prefix
        send(8'hE0); send(8'h74);
        tick();
        chk("held_right", 32'(held_arrows), 32'h1);
        send(8'hE0); send(8'h6B, 1'b1);
        chk("ferr_noevt", 32'(evt_valid), 32'h0);
        send(8'h6B);
        chk_evt("ferr_plain", 1, 0, 0, 8'h6B);
        chk("keypad_nochg", 32'(held_arrows), 32'h1);
        tick();

        // reset mid-sequence clears everything, no partial event survives
        send(8'hE0); send(8'hF0);
        rst = 1'b1; #1;
        chk("midrst_outs", 32'({evt_valid, evt_code, evt_ext, evt_break, held_arrows, overflow, seq_timeout}), 32'h0);
        tick(); tick();
        chk("rst_hold", 32'({evt_valid, evt_code, held_arrows, overflow}), 32'h0);
        rst = 1'b0;
        tick();
        send(8'h74);
        chk_evt("post_rst", 1, 0, 0, 8'h74);
        chk("post_rst_held", 32'(held_arrows), 32'h0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
